fetch_unit: RTL

- Instruction-fetch stage of the 5-stage RISC-V pipeline.
- Owns the PC register, computes PC+4, and applies EX-stage branch/jump redirects.
- Runs a single-outstanding request/response handshake to instruction memory.
- Presents the instruction, PC and PC+4, qualified by a valid flag, directly to the IF/ID pipeline register's fetch-side inputs.

---
 rtl/fetch_unit_pkg.sv | 15 +
 rtl/fetch_unit_if.sv | 35 +++
 rtl/fetch_unit_pc_gen.sv | 39 +++
 rtl/fetch_unit.sv | 106 ++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared constants for the instruction-fetch stage: FSM encoding, reset PC, PC increment.
// Latency: n/a (constants only).
// Backpressure: n/a.
package riscv_fetch_pkg;

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_DROP = 2'd3;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage signal bundle: redirect/stall inputs, imem handshake, IF/ID-side outputs.
// Latency: n/a (wires only).
// Backpressure: imem ready and the hazard stall travel through this bundle.
interface fetch_unit_if #(
  parameter int PC_Width        = 32,
  parameter int Inst_Data_width = 32
);

  logic                       i_StallF;
  logic                       i_PCSrc_E;
  logic [PC_Width-1:0]        i_PCTarget_E;
  logic                       o_Imem_Req;
  logic [PC_Width-1:0]        o_Imem_Addr;
  logic                       i_Imem_Rdy;
  logic                       i_Imem_RValid;
  logic [Inst_Data_width-1:0] i_Imem_RData;
  logic [Inst_Data_width-1:0] o_Instr_F;
  logic [PC_Width-1:0]        o_PC_F;
  logic [PC_Width-1:0]        o_PCPluse4_F;
  logic                       o_Valid_F;
  logic                       o_Misaligned_F;

  // Fetch unit side.
  modport master (
    input  i_StallF, i_PCSrc_E, i_PCTarget_E, i_Imem_Rdy, i_Imem_RValid, i_Imem_RData,
    output o_Imem_Req, o_Imem_Addr, o_Instr_F, o_PC_F, o_PCPluse4_F, o_Valid_F, o_Misaligned_F
  );

  // Environment side (hazard unit, EX stage, instruction memory, IF/ID).
  modport slave (
    output i_StallF, i_PCSrc_E, i_PCTarget_E, i_Imem_Rdy, i_Imem_RValid, i_Imem_RData,
    input  o_Imem_Req, o_Imem_Addr, o_Instr_F, o_PC_F, o_PCPluse4_F, o_Valid_F, o_Misaligned_F
  );

endinterface

// File: rtl/fetch_unit_pc_gen.sv
// PC register with +4 adder and redirect mux; FETCH_MISALIGN_CHK_EN keeps target[1:0].
// Latency: new PC visible the cycle after a load.
// Backpressure: none; the PC only moves on load_seq or load_redirect.
module fetch_pc_gen
  import riscv_fetch_pkg::*;
#(
  parameter int                  PC_Width = 32,
  parameter logic [PC_Width-1:0] RESET_PC = PC_Width'(DEFAULT_RESET_PC)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_seq,
  input  logic                load_redirect,
  input  logic [PC_Width-1:0] target,
  output logic [PC_Width-1:0] pc,
  output logic [PC_Width-1:0] pc_plus4
);

  logic [PC_Width-1:0] tgt;

`ifdef FETCH_MISALIGN_CHK_EN
  // Misaligned targets are loaded as-is; the fetch FSM flags and blocks them.
  assign tgt = target;
`else
  // Without the checker, redirects are forced onto a word boundary.
  assign tgt = target & ~PC_Width'(3);
`endif

  // Adder wraps modulo 2^PC_Width.
  assign pc_plus4 = pc + PC_Width'(PC_INC);

  // Redirect outranks the sequential advance.
  always_ff @(posedge clk) begin
    if (rst)                pc <= RESET_PC;
    else if (load_redirect) pc <= tgt;
    else if (load_seq)      pc <= pc_plus4;
  end

endmodule

// File: rtl/fetch_unit.sv
// IF stage: single-outstanding imem fetch, EX redirects, IF/ID-side outputs; FETCH_MISALIGN_CHK_EN adds a misaligned-redirect flag.
// Latency: request-to-valid 1 cycle + memory latency; 1 instruction per 3 cycles with zero-wait memory.
// Backpressure: i_Imem_Rdy holds the request in S_REQ; i_StallF holds the instruction in S_HOLD.
module fetch_unit
  import riscv_fetch_pkg::*;
#(
  parameter int                  PC_Width        = 32,
  parameter int                  Inst_Data_width = 32,
  parameter logic [PC_Width-1:0] RESET_PC        = PC_Width'(DEFAULT_RESET_PC)
) (
  input logic        clk,
  input logic        rst,
  fetch_unit_if.master f
);

  logic [1:0]                 state, state_nxt;
  logic [PC_Width-1:0]        pc, pc_plus4;
  logic                       mis;
  logic                       req, accept, load_seq, capture, release_hold;
  logic [Inst_Data_width-1:0] instr_q;
  logic [PC_Width-1:0]        pc_q, pc_plus4_q;
  logic                       valid_q;

  fetch_pc_gen #(
    .PC_Width (PC_Width),
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk           (clk),
    .rst           (rst),
    .load_seq      (load_seq),
    .load_redirect (f.i_PCSrc_E),
    .target        (f.i_PCTarget_E),
    .pc            (pc),
    .pc_plus4      (pc_plus4)
  );

  // A flagged misaligned PC never reaches memory, so the request is withheld.
  assign req          = (state == S_REQ) && !mis;
  assign accept       = req && f.i_Imem_Rdy;
  assign capture      = (state == S_WAIT) && f.i_Imem_RValid && !f.i_PCSrc_E;
  assign release_hold = (state == S_HOLD) && (f.i_PCSrc_E || !f.i_StallF);
  assign load_seq     = (state == S_HOLD) && !f.i_PCSrc_E && !f.i_StallF;

  // Next-state: redirect first, then response/consume, then stall.
  always_comb begin
    state_nxt = state;
    case (state)
      S_REQ: begin
        if (accept) state_nxt = f.i_PCSrc_E ? S_DROP : S_WAIT;
      end
      S_WAIT: begin
        if (f.i_PCSrc_E)         state_nxt = f.i_Imem_RValid ? S_REQ : S_DROP;
        else if (f.i_Imem_RValid) state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (release_hold) state_nxt = S_REQ;
      end
      default: begin
        // S_DROP: the stale response retires the old request.
        if (f.i_Imem_RValid) state_nxt = S_REQ;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_REQ;
    else     state <= state_nxt;
  end

  // IF/ID-side output registers; only valid drops when the instruction leaves.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q    <= '0;
      pc_q       <= '0;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else if (capture) begin
      instr_q    <= f.i_Imem_RData;
      pc_q       <= pc;
      pc_plus4_q <= pc_plus4;
      valid_q    <= 1'b1;
    end else if (release_hold) begin
      valid_q    <= 1'b0;
    end
  end

`ifdef FETCH_MISALIGN_CHK_EN
  // Every redirect re-evaluates alignment of its target.
  always_ff @(posedge clk) begin
    if (rst)              mis <= 1'b0;
    else if (f.i_PCSrc_E) mis <= |f.i_PCTarget_E[1:0];
  end
`else
  assign mis = 1'b0;
`endif

  assign f.o_Imem_Req     = req;
  assign f.o_Imem_Addr    = pc;
  assign f.o_Instr_F      = instr_q;
  assign f.o_PC_F         = pc_q;
  assign f.o_PCPluse4_F   = pc_plus4_q;
  assign f.o_Valid_F      = valid_q;
  assign f.o_Misaligned_F = mis;

endmodule
